// File: rtl/layer_2_stream_ctrl.sv
// layer_2_stream_ctrl
// Frame sequencer for a layer-2 feature-map stage: walks the (optionally
// zero-padded) input frame in raster order, pulls interior pixels from an
// upstream valid/ready source, drives the shared conv bus, counts returned
// result beats and pulses done once the output map is complete.
// Build option: define LAYER2_STREAM_CTRL_PAD_EN to add a one-pixel zero border.
module layer_2_stream_ctrl #(
   parameter int IMG_SIZE   = 208,
   parameter int DATA_WIDTH = 512
) (
   input  logic                  Clk,
   input  logic                  Rst,
   input  logic                  start,
   input  logic [DATA_WIDTH-1:0] src_data,
   input  logic                  src_valid,
   output logic                  src_ready,
   output logic [DATA_WIDTH-1:0] conv_data,
   output logic                  conv_valid,
   input  logic                  res_valid,
   output logic                  busy,
   output logic                  done,
   output logic                  err
);

`ifdef LAYER2_STREAM_CTRL_PAD_EN
   localparam int F     = IMG_SIZE + 2;
   localparam int N_OUT = IMG_SIZE * IMG_SIZE;
`else
   localparam int F     = IMG_SIZE;
   localparam int N_OUT = (IMG_SIZE - 2) * (IMG_SIZE - 2);
`endif

   localparam int PW = $clog2(IMG_SIZE + 2);
   localparam int NW = $clog2(IMG_SIZE * IMG_SIZE + 1);

   localparam logic [PW-1:0] POS_LAST = PW'(F - 1);
   localparam logic [NW-1:0] N_FULL   = NW'(N_OUT);
   localparam logic [NW-1:0] N_PRE    = NW'(N_OUT - 1);

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_RUN   = 2'd1,
      S_DRAIN = 2'd2,
      S_DONE  = 2'd3
   } state_t;

   state_t          state_reg, state_next;
   logic [PW-1:0]   r_reg, c_reg;
   logic [NW-1:0]   n_reg;
   logic            err_reg;

   logic            border;
   logic            emit;
   logic            last_pos;
   logic            n_hit;

   // Position classification and the per-cycle emission decision.
   always_comb begin
`ifdef LAYER2_STREAM_CTRL_PAD_EN
      border = (r_reg == '0) || (r_reg == POS_LAST) ||
               (c_reg == '0) || (c_reg == POS_LAST);
`else
      border = 1'b0;
`endif
      // A border position always emits; an interior one only on accept.
      emit     = (state_reg == S_RUN) && (border || src_valid);
      last_pos = (r_reg == POS_LAST) && (c_reg == POS_LAST);
      // The beat that brings n to N_OUT moves the FSM on at the same edge.
      n_hit    = (n_reg == N_FULL) || (res_valid && (n_reg == N_PRE));
   end

   // State register.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         state_reg <= S_IDLE;
      end else begin
         state_reg <= state_next;
      end
   end

   // Next-state logic.
   always_comb begin
      state_next = state_reg;
      case (state_reg)
         S_IDLE: begin
            if (start) begin
               state_next = S_RUN;
            end
         end
         S_RUN: begin
            if (n_hit) begin
               state_next = S_DONE;
            end else if (emit && last_pos) begin
               state_next = S_DRAIN;
            end
         end
         S_DRAIN: begin
            if (n_hit) begin
               state_next = S_DONE;
            end
         end
         S_DONE: begin
            state_next = S_IDLE;
         end
         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   // Output decode: handshake ready, busy and the done pulse.
   always_comb begin
      src_ready = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_reg)
         S_IDLE: begin
            busy = 1'b0;
         end
         S_RUN: begin
            busy      = 1'b1;
            src_ready = !border;
         end
         S_DRAIN: begin
            busy = 1'b1;
         end
         S_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   // Raster position: column runs fastest, row advances on column wrap.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         r_reg <= '0;
         c_reg <= '0;
      end else if ((state_reg == S_IDLE) && start) begin
         r_reg <= '0;
         c_reg <= '0;
      end else if (emit) begin
         if (c_reg == POS_LAST) begin
            c_reg <= '0;
            r_reg <= (r_reg == POS_LAST) ? '0 : r_reg + PW'(1);
         end else begin
            c_reg <= c_reg + PW'(1);
         end
      end
   end

   // Registered conv bus: zero on border, source pixel on accept, bubble otherwise.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         conv_valid <= 1'b0;
         conv_data  <= '0;
      end else if (emit) begin
         conv_valid <= 1'b1;
         conv_data  <= border ? '0 : src_data;
      end else begin
         conv_valid <= 1'b0;
         conv_data  <= '0;
      end
   end

   // Result counter (saturating at N_OUT) and sticky overrun / stray-beat error.
   always_ff @(posedge Clk) begin
      if (Rst) begin
         n_reg   <= '0;
         err_reg <= 1'b0;
      end else begin
         if ((state_reg == S_IDLE) && start) begin
            n_reg <= '0;
         end else if (((state_reg == S_RUN) || (state_reg == S_DRAIN)) &&
                      res_valid && (n_reg != N_FULL)) begin
            n_reg <= n_reg + NW'(1);
         end
         if (res_valid && ((state_reg == S_IDLE) || (state_reg == S_DONE) ||
                           (n_reg == N_FULL))) begin
            err_reg <= 1'b1;
         end
      end
   end

   assign err = err_reg;

endmodule

// File: tb/tb_layer_2_stream_ctrl.sv
// Self-checking bench for layer_2_stream_ctrl (IMG_SIZE = 4).
// The reference model builds the expected beat stream of a frame directly
// from the frame geometry: every position in raster order is either a zero
// border beat or the next source pixel.
module tb_layer_2_stream_ctrl;

   localparam int IMG = 4;
   localparam int DW  = 512;
`ifdef LAYER2_STREAM_CTRL_PAD_EN
   localparam int F     = IMG + 2;
   localparam int N_OUT = IMG * IMG;
`else
   localparam int F     = IMG;
   localparam int N_OUT = (IMG - 2) * (IMG - 2);
`endif

   logic          Clk = 1'b0;
   logic          Rst;
   logic          start;
   logic [DW-1:0] src_data;
   logic          src_valid;
   logic          src_ready;
   logic [DW-1:0] conv_data;
   logic          conv_valid;
   logic          res_valid;
   logic          busy;
   logic          done;
   logic          err;

   int n_assert = 0;
   int n_fail   = 0;

   layer_2_stream_ctrl #(
      .IMG_SIZE   (IMG),
      .DATA_WIDTH (DW)
   ) dut (
      .Clk        (Clk),
      .Rst        (Rst),
      .start      (start),
      .src_data   (src_data),
      .src_valid  (src_valid),
      .src_ready  (src_ready),
      .conv_data  (conv_data),
      .conv_valid (conv_valid),
      .res_valid  (res_valid),
      .busy       (busy),
      .done       (done),
      .err        (err)
   );

   always #5 Clk = ~Clk;

   task automatic check(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   function automatic logic [DW-1:0] rand_pix();
      logic [DW-1:0] v;
      for (int i = 0; i < DW / 32; i++) begin
         v[i*32 +: 32] = $urandom();
      end
      return v;
   endfunction

   function automatic bit is_border(input int p);
      int r;
      int c;
      r = p / F;
      c = p % F;
`ifdef LAYER2_STREAM_CTRL_PAD_EN
      return (r == 0) || (r == F - 1) || (c == 0) || (c == F - 1);
`else
      return (r < 0) || (c < 0);
`endif
   endfunction

   // One frame: stall selects every-other-cycle source gaps and random result
   // gaps, res_beats is how many result beats the stage model returns, and
   // abort_pos >= 0 pulses Rst when the walk reaches that position.
   task automatic run_frame(input string name, input int stall, input int res_beats,
                            input int abort_pos);
      logic [DW-1:0] src_q[$];
      logic [DW-1:0] exp_q[$];
      int idx, pos, beats, zeros, accepts, dones, res_sent;
      int exp_done_cyc, last_res_cyc, budget;
      bit exp_valid, exp_rdy, finished;

      for (int i = 0; i < IMG * IMG; i++) src_q.push_back(rand_pix());
      idx = 0;
      for (int p = 0; p < F * F; p++) begin
         if (is_border(p)) exp_q.push_back('0);
         else begin
            exp_q.push_back(src_q[idx]);
            idx++;
         end
      end

      pos = 0; beats = 0; zeros = 0; accepts = 0; dones = 0; res_sent = 0;
      exp_done_cyc = -1; last_res_cyc = -10; exp_valid = 0; finished = 0;
      budget = 3 * F * F + 100;

      check({name, "_idle_busy"}, busy, 0);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;

      for (int cyc = 0; cyc < budget; cyc++) begin
         check({name, "_conv_valid"}, conv_valid, exp_valid);
         if (conv_valid) begin
            beats++;
            if (conv_data === '0) zeros++;
            if (exp_q.size() > 0) check({name, "_beat_data"}, conv_data, exp_q.pop_front());
            else check({name, "_beat_overflow"}, beats, F * F);
         end
         check({name, "_done"}, done, cyc == exp_done_cyc);
         if (done) dones++;
         check({name, "_busy"}, busy, !(exp_done_cyc >= 0 && cyc > exp_done_cyc));

         res_valid = 1'b0;
         if (exp_done_cyc >= 0 && cyc > exp_done_cyc && cyc > last_res_cyc + 1 &&
             res_sent == res_beats) begin
            finished = 1;
            break;
         end

         if (abort_pos >= 0 && pos == abort_pos) begin
            Rst = 1'b1;
            @(negedge Clk);
            Rst = 1'b0;
            check({name, "_abort_conv_valid"}, conv_valid, 0);
            check({name, "_abort_busy"}, busy, 0);
            check({name, "_abort_err"}, err, 0);
            check({name, "_abort_src_ready"}, src_ready, 0);
            for (int k = 0; k < 6; k++) begin
               @(negedge Clk);
               check({name, "_abort_no_done"}, done, 0);
            end
            $display("frame %s: aborted at position %0d after %0d beats", name, pos, beats);
            src_valid = 1'b0;
            return;
         end

         // Stage model: result beats start no earlier than the last position.
         if (pos >= F * F - 1 && res_sent < res_beats &&
             (stall == 0 || $urandom_range(0, 1) == 1)) begin
            res_valid = 1'b1;
            res_sent++;
            last_res_cyc = cyc;
            if (res_sent == N_OUT) exp_done_cyc = cyc + 1;
         end

         src_valid = (stall == 0) || (cyc % 2 == 1);
         src_data  = rand_pix();
         if (pos < F * F) begin
            exp_rdy = !is_border(pos);
            check({name, "_src_ready"}, src_ready, exp_rdy);
            if (exp_rdy && src_valid) begin
               src_data = src_q.pop_front();
               accepts++;
            end
            exp_valid = !exp_rdy || src_valid;
            if (exp_valid) pos++;
         end else begin
            check({name, "_src_ready_drain"}, src_ready, 0);
            exp_valid = 0;
         end
         @(negedge Clk);
      end

      res_valid = 1'b0;
      src_valid = 1'b0;
      check({name, "_finished_in_budget"}, finished, 1);
      check({name, "_beats"}, beats, F * F);
      check({name, "_zero_beats"}, zeros, F * F - IMG * IMG);
      check({name, "_accepts"}, accepts, IMG * IMG);
      check({name, "_dones"}, dones, 1);
      check({name, "_exp_left"}, exp_q.size(), 0);
      check({name, "_err"}, err, res_beats > N_OUT);
      check({name, "_busy_end"}, busy, 0);
      $display("frame %s: beats=%0d zeros=%0d accepts=%0d results=%0d done=%0d err=%0b",
               name, beats, zeros, accepts, res_sent, dones, err);
   endtask

   initial begin
      Rst       = 1'b1;
      start     = 1'b0;
      src_valid = 1'b1;
      src_data  = rand_pix();
      res_valid = 1'b0;

      // Reset then idle with the source offering data.
      repeat (2) @(negedge Clk);
      Rst = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge Clk);
         check("idle_src_ready", src_ready, 0);
         check("idle_conv_valid", conv_valid, 0);
         check("idle_conv_data", conv_data, 0);
         check("idle_done", done, 0);
         check("idle_busy", busy, 0);
         check("idle_err", err, 0);
      end
      $display("reset/idle: 10 idle cycles observed");
      src_valid = 1'b0;

      run_frame("full", 0, N_OUT, -1);
      repeat (3) @(negedge Clk);

      run_frame("stall", 1, N_OUT, -1);
      repeat (3) @(negedge Clk);

      run_frame("overrun", 0, N_OUT + 1, -1);
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         check("overrun_err_sticky", err, 1);
      end
      Rst = 1'b1;
      @(negedge Clk);
      Rst = 1'b0;
      check("overrun_err_cleared", err, 0);
      check("overrun_busy_after_rst", busy, 0);
      $display("overrun: err cleared by reset");
      repeat (2) @(negedge Clk);

      run_frame("abort", 0, 0, 2 * F + 3);
      run_frame("restart", 0, N_OUT, -1);
      repeat (2) @(negedge Clk);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/layer_2_stream_ctrl.md
# layer_2_stream_ctrl

Sequencer feeding one layer-2 feature-map stage (16 parallel 3x3 convolution engines sharing a 512-bit input bus). On `start` it walks the input frame in raster order, pulls pixels from an upstream source with a valid/ready handshake, and inserts a zero-padding border. It drives the shared `data_in`/`valid_in` bus, counts result beats returned by the stage, and pulses `done` when the full output map has been produced.

## Interface
Parameters:
- `IMG_SIZE`, 208: input frame width and height in pixels.
- `DATA_WIDTH`, 512: bus width, 16 channels x 32-bit float.

Ports (one clock; reset is synchronous and active-high):
- `Clk`  in  1  clock; all logic on the rising edge.
- `Rst`  in  1  synchronous, active-high reset.
- `start`  in  1  one-cycle request to process a frame; honoured only in IDLE.
- `src_data`  in  DATA_WIDTH  upstream pixel, all 16 channels.
- `src_valid`  in  1  upstream pixel available.
- `src_ready`  out  1  controller accepts `src_data` this cycle.
- `conv_data`  out  DATA_WIDTH  to the feature-map stage `data_in`.
- `conv_valid`  out  1  to the feature-map stage `valid_in`.
- `res_valid`  in  1  the stage's `valid_out`; one result pixel per high cycle.
- `busy`  out  1  high in every state except IDLE.
- `done`  out  1  one-cycle pulse at end of frame.
- `err`  out  1  sticky; set when `res_valid` arrives in IDLE or DONE. Cleared only by `Rst`.

## Operation
- States: IDLE, RUN, DRAIN, DONE.
- IDLE -> RUN on `start`. Row counter `r` and column counter `c` are cleared. Output counter `n` is cleared.
- RUN: the frame is F x F positions, visited row-major (`c` increments, wraps at F-1 to 0 and increments `r`).
  - Border position (`r`==0, `r`==F-1, `c`==0 or `c`==F-1): emit a zero pixel (`conv_valid`=1, `conv_data`=0) and advance. `src_ready`=0.
  - Interior position: `src_ready`=1. On accept (`src_valid`&&`src_ready`), emit `src_data` and advance. Without `src_valid`, emit a bubble (`conv_valid`=0) and hold the position.
- RUN -> DRAIN after the last position (`r`==F-1, `c`==F-1) is emitted.
- DRAIN: no emission, `src_ready`=0. Wait until `n` reaches N_OUT.
- `n` increments on every `res_valid` in RUN or DRAIN. Once `n`==N_OUT, further `res_valid` sets `err` and `n` saturates.
- Reaching `n`==N_OUT moves the FSM to DONE, from either RUN or DRAIN.
- DONE: `done`=1 for exactly one cycle, then IDLE.
- `start` outside IDLE is ignored.
- Counter widths:
  - `r` and `c`: $clog2(IMG_SIZE+2) bits.
  - `n`: $clog2(IMG_SIZE*IMG_SIZE+1) bits.

## Timing
- Reset values: `src_ready`=0, `conv_valid`=0, `conv_data`=0, `done`=0, `busy`=0, `err`=0, state=IDLE, all counters 0.
- `Rst` mid-frame aborts in the cycle after the edge. No `done` pulse is produced; `err` clears.
- `src_ready` is combinational from state and position. It does not depend on `src_valid`.
- `conv_data` and `conv_valid` are registered and appear 1 cycle after the accept or border decision.
- First `conv_valid` appears 2 cycles after the `start` cycle: IDLE->RUN, then the first position is registered.
- `busy` rises the cycle after `start` and falls the cycle after `done`.
- `res_valid` landing on the same cycle as the last emission is counted normally.
- With no stalls, RUN lasts exactly F*F cycles.

## Configuration
- Macro `LAYER2_STREAM_CTRL_PAD_EN`.
- Defined: padding enabled. F = IMG_SIZE+2, N_OUT = IMG_SIZE*IMG_SIZE, border positions are zero-injected.
- Undefined: no padding. F = IMG_SIZE, every position is interior (all pixels come from the source), N_OUT = (IMG_SIZE-2)*(IMG_SIZE-2).

## Test plan
- Reset, idle: hold `Rst` for 2 cycles, then idle 10 cycles with `src_valid`=1. Required: all outputs stay at reset values and `src_ready` stays 0.
- Padded full frame: `IMG_SIZE`=4, `src_valid` always 1, stage model returns 16 `res_valid` beats.
  - Required: 36 `conv_valid` beats, of which 20 are zero border beats.
  - 16 source accepts, in raster order.
  - `done` pulses once, then `busy`=0.
- Source stalls: same frame with `src_valid` low every other cycle. Required: bubbles are emitted only at interior positions, the pixel sequence is unchanged, and there are still 36 valid beats and 1 `done`.
- Result overrun: the stage model returns 17 `res_valid` beats. Required: `done` after the 16th beat, `err`=1 after the 17th, and `err` stays 1 until `Rst`.
- Abort and restart: assert `Rst` at position (2,3), then `start` again. Required: no `done` from the aborted frame, and the new frame completes with 36 beats.
- Macro undefined, `IMG_SIZE`=4: required 16 beats all from the source, no zero beats, and `done` after 4 `res_valid` beats.
